// File: rtl/fpu_mult_pkg.sv
// fpu_mult_pkg: shared types and constants for the sequential significand
// multiplier.
//   mult_state_t : FSM encoding (IDLE, BUSY, DONE)
//   calc_iters() : number of BUSY cycles for a WIDTH / BITS_PER_CYCLE pair
//   SP_SIG_W / DP_SIG_W : single / double precision significand widths
package fpu_mult_pkg;

  localparam int SP_SIG_W = 24;
  localparam int DP_SIG_W = 53;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic int calc_iters(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/fpu_mult_pp.sv
// fpu_mult_pp: combinational partial-product generator.
//   mcand : WIDTH-bit unsigned multiplicand
//   digit : BITS_PER_CYCLE-bit multiplier digit
//   pp    : WIDTH+BITS_PER_CYCLE-bit exact product mcand * digit
// Kept as its own block so a Booth-recoded generator can drop in later.
module fpu_mult_pp #(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [WIDTH-1:0]                mcand,
  input  logic [BITS_PER_CYCLE-1:0]       digit,
  output logic [WIDTH+BITS_PER_CYCLE-1:0] pp
);

  always_comb begin
    pp = {{BITS_PER_CYCLE{1'b0}}, mcand} * {{WIDTH{1'b0}}, digit};
  end

endmodule

// File: rtl/fpu_mult_seq.sv
// fpu_mult_seq: sequential WIDTH x WIDTH -> 2*WIDTH unsigned multiplier,
// retiring BITS_PER_CYCLE multiplier bits per BUSY cycle.
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : operand handshake (multiplicand, multiplier)
//   out_valid/out_ready         : product handshake (product)
//   flush                       : synchronous abort back to IDLE
//   busy                        : high in BUSY or DONE
// Optional feature macro FPU_MULT_EARLY_OUT_EN: finish as soon as the
// remaining multiplier bits are all zero.
module fpu_mult_seq
  import fpu_mult_pkg::*;
#(
  parameter int WIDTH          = SP_SIG_W,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ITERS = calc_iters(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = $clog2(ITERS + 1);
  // The shifted multiplicand never has a set bit above 2*WIDTH-BITS_PER_CYCLE-1
  // while it is still being used (max shift is WIDTH-BITS_PER_CYCLE), so its
  // top BITS_PER_CYCLE bits are not stored and the partial product is exactly
  // 2*WIDTH bits wide.
  localparam int MW    = 2*WIDTH - BITS_PER_CYCLE;

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("fpu_mult_seq: BITS_PER_CYCLE must divide WIDTH");
  end

  mult_state_t           state_q, state_d;
  logic [MW-1:0]         mcand_sh_q, mcand_sh_d;
  logic [WIDTH-1:0]      mplier_sh_q, mplier_sh_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [2*WIDTH-1:0]    product_q, product_d;

  logic [2*WIDTH-1:0]    pp;
  logic [2*WIDTH-1:0]    acc_sum;
  logic                  last_iter;

  fpu_mult_pp #(
    .WIDTH          (MW),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_pp (
    .mcand (mcand_sh_q),
    .digit (mplier_sh_q[BITS_PER_CYCLE-1:0]),
    .pp    (pp)
  );

  always_comb begin
    acc_sum = acc_q + pp;
`ifdef FPU_MULT_EARLY_OUT_EN
    // Nothing left to add once the remaining multiplier bits are zero.
    last_iter = (cnt_q == CW'(ITERS - 1)) ||
                ((mplier_sh_q >> BITS_PER_CYCLE) == '0);
`else
    last_iter = (cnt_q == CW'(ITERS - 1));
`endif
  end

  always_comb begin
    state_d     = state_q;
    mcand_sh_d  = mcand_sh_q;
    mplier_sh_d = mplier_sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    product_d   = product_q;

    if (flush) begin
      // Abort wins over everything; product keeps its last value.
      state_d     = IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_sh_d  = MW'(multiplicand);
            mplier_sh_d = multiplier;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = BUSY;
            in_ready_d  = 1'b0;
            busy_d      = 1'b1;
          end
        end
        BUSY: begin
          acc_d       = acc_sum;
          mcand_sh_d  = mcand_sh_q << BITS_PER_CYCLE;
          mplier_sh_d = mplier_sh_q >> BITS_PER_CYCLE;
          cnt_d       = cnt_q + 1'b1;
          if (last_iter) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            product_d   = acc_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_sh_q  <= '0;
      mplier_sh_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      mcand_sh_q  <= mcand_sh_d;
      mplier_sh_q <= mplier_sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// tb_fpu_mult_seq: directed table plus corner sequences on the default
// 24x24 / radix-4 instance, and random sweeps on 53x53 radix-2 and
// 52x52 radix-16 instances.
module tb_fpu_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // default instance
  logic        iv0 = 0, fl0 = 0, or0 = 0;
  logic [23:0] a0 = '0, b0 = '0;
  logic        ir0, ov0, bz0;
  logic [47:0] p0;

  fpu_mult_seq #(.WIDTH(24), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .multiplicand(a0), .multiplier(b0), .flush(fl0), .out_valid(ov0),
    .out_ready(or0), .product(p0), .busy(bz0));

  // double-precision width, radix-2
  logic         iv1 = 0, fl1 = 0, or1 = 0;
  logic [52:0]  a1 = '0, b1 = '0;
  logic         ir1, ov1, bz1;
  logic [105:0] p1;

  fpu_mult_seq #(.WIDTH(53), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .multiplicand(a1), .multiplier(b1), .flush(fl1), .out_valid(ov1),
    .out_ready(or1), .product(p1), .busy(bz1));

  // 52-bit, radix-16
  logic         iv2 = 0, fl2 = 0, or2 = 0;
  logic [51:0]  a2 = '0, b2 = '0;
  logic         ir2, ov2, bz2;
  logic [103:0] p2;

  fpu_mult_seq #(.WIDTH(52), .BITS_PER_CYCLE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .multiplicand(a2), .multiplier(b2), .flush(fl2), .out_valid(ov2),
    .out_ready(or2), .product(p2), .busy(bz2));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected cycles from accept edge to out_valid.
  function automatic int exp_lat(input logic [63:0] b, input int w, input int bpc);
`ifdef FPU_MULT_EARLY_OUT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < w; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + bpc) / bpc;
`else
    return w / bpc;
`endif
  endfunction

  task automatic op0(input logic [23:0] a, input logic [23:0] b,
                     output logic [47:0] p, output int lat);
    @(negedge clk); a0 = a; b0 = b; iv0 = 1'b1;
    @(posedge clk); #1 iv0 = 1'b0;
    lat = 0;
    while (!ov0 && lat < 200) begin @(posedge clk); #1; lat++; end
    p = p0;
  endtask

  task automatic hs0();
    or0 = 1'b1;
    @(posedge clk); #1 or0 = 1'b0;
  endtask

  task automatic op1(input logic [52:0] a, input logic [52:0] b,
                     output logic [105:0] p, output int lat);
    @(negedge clk); a1 = a; b1 = b; iv1 = 1'b1;
    @(posedge clk); #1 iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 200) begin @(posedge clk); #1; lat++; end
    p = p1;
    or1 = 1'b1;
    @(posedge clk); #1 or1 = 1'b0;
  endtask

  task automatic op2(input logic [51:0] a, input logic [51:0] b,
                     output logic [103:0] p, output int lat);
    @(negedge clk); a2 = a; b2 = b; iv2 = 1'b1;
    @(posedge clk); #1 iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 200) begin @(posedge clk); #1; lat++; end
    p = p2;
    or2 = 1'b1;
    @(posedge clk); #1 or2 = 1'b0;
  endtask

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  vec_t        tbl[7];
  logic [47:0] pr;
  logic [47:0] held;
  int          lat;
  logic        seen;

  initial begin
    tbl[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    tbl[1] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000};
    tbl[2] = '{24'hABCDEF, 24'h000000, 48'h000000000000};
    tbl[3] = '{24'h123456, 24'hABCDEF, 48'h0C379A59BA4A};
    tbl[4] = '{24'hABCDEF, 24'h123456, 48'h0C379A59BA4A};
    tbl[5] = '{24'h000001, 24'h000001, 48'h000000000001};
    tbl[6] = '{24'hABCDEF, 24'h000001, 48'h000000ABCDEF};

    // reset / idle
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(ir0), 128'(1'b1));
    chk("rst_out_valid", 128'(ov0), 128'(1'b0));
    chk("rst_busy", 128'(bz0), 128'(1'b0));
    chk("rst_product", 128'(p0), 128'(0));

    // identity with timing and output back-pressure
    op0(24'h800000, 24'h800000, pr, lat);
    chk("id_product", 128'(pr), 128'(48'h400000000000));
    chk("id_latency", 128'(lat), 128'(exp_lat(64'h800000, 24, 2)));
    held = p0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("id_hold_product", 128'(p0), 128'(held));
      chk("id_hold_valid", 128'(ov0), 128'(1'b1));
      chk("id_hold_in_ready", 128'(ir0), 128'(1'b0));
    end
    hs0();
    chk("id_ret_valid", 128'(ov0), 128'(1'b0));
    chk("id_ret_in_ready", 128'(ir0), 128'(1'b1));
    chk("id_ret_busy", 128'(bz0), 128'(1'b0));

    // flush in BUSY
    @(negedge clk); a0 = 24'h123456; b0 = 24'hABCDEF; iv0 = 1'b1;
    @(posedge clk); #1 iv0 = 1'b0;
    chk("fl_busy", 128'(bz0), 128'(1'b1));
    repeat (5) @(posedge clk);
    @(negedge clk); fl0 = 1'b1;
    @(posedge clk); #1 fl0 = 1'b0;
    chk("fl_in_ready", 128'(ir0), 128'(1'b1));
    chk("fl_busy_low", 128'(bz0), 128'(1'b0));
    chk("fl_product_kept", 128'(p0), 128'(48'h400000000000));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; seen |= ov0; end
    chk("fl_no_out_valid", 128'(seen), 128'(1'b0));

    // flush in IDLE blocks acceptance
    @(negedge clk); a0 = 24'h000003; b0 = 24'h000003; iv0 = 1'b1; fl0 = 1'b1;
    @(posedge clk); #1 iv0 = 1'b0; fl0 = 1'b0;
    chk("fl_idle_in_ready", 128'(ir0), 128'(1'b1));
    chk("fl_idle_busy", 128'(bz0), 128'(1'b0));

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      op0(tbl[i].a, tbl[i].b, pr, lat);
      chk("tbl_product", 128'(pr), 128'(tbl[i].p));
      chk("tbl_latency", 128'(lat), 128'(exp_lat(64'(tbl[i].b), 24, 2)));
      hs0();
      chk("tbl_idle", 128'({ov0, ir0}), 128'(2'b01));
    end

    // reset mid-operation
    @(negedge clk); a0 = 24'h00F00F; b0 = 24'h0F0F0F; iv0 = 1'b1;
    @(posedge clk); #1 iv0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_in_ready", 128'(ir0), 128'(1'b1));
    chk("rstmid_out_valid", 128'(ov0), 128'(1'b0));
    chk("rstmid_busy", 128'(bz0), 128'(1'b0));
    chk("rstmid_product", 128'(p0), 128'(0));
    @(negedge clk); rst_n = 1'b1;

    // back-to-back: operands during BUSY ignored, next pair taken after handshake
    @(negedge clk); a0 = 24'd3; b0 = 24'd5; iv0 = 1'b1;
    @(posedge clk); #1 a0 = 24'd7; b0 = 24'd9;
    lat = 0;
    while (!ov0 && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_first", 128'(p0), 128'(48'd15));
    chk("b2b_first_lat", 128'(lat), 128'(exp_lat(64'd5, 24, 2)));
    chk("b2b_in_ready_low", 128'(ir0), 128'(1'b0));
    or0 = 1'b1;
    @(posedge clk); #1 or0 = 1'b0;
    chk("b2b_hs_in_ready", 128'(ir0), 128'(1'b1));
    @(posedge clk); #1 iv0 = 1'b0;
    chk("b2b_second_accept", 128'(bz0), 128'(1'b1));
    lat = 0;
    while (!ov0 && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_second", 128'(p0), 128'(48'd63));
    hs0();

    // parametric random sweeps
    for (int i = 0; i < 200; i++) begin
      logic [52:0]  ra, rb;
      logic [105:0] rp;
      int           rl;
      ra = 53'({$urandom(), $urandom()});
      rb = 53'({$urandom(), $urandom()}) >> $urandom_range(0, 53);
      op1(ra, rb, rp, rl);
      chk("w53_product", 128'(rp), 128'({53'd0, ra} * {53'd0, rb}));
      chk("w53_latency", 128'(rl), 128'(exp_lat(64'(rb), 53, 1)));
    end
    for (int i = 0; i < 200; i++) begin
      logic [51:0]  ra, rb;
      logic [103:0] rp;
      int           rl;
      ra = 52'({$urandom(), $urandom()});
      rb = 52'({$urandom(), $urandom()}) >> $urandom_range(0, 52);
      op2(ra, rb, rp, rl);
      chk("w52_product", 128'(rp), 128'({52'd0, ra} * {52'd0, rb}));
      chk("w52_latency", 128'(rl), 128'(exp_lat(64'(rb), 52, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
